// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------
// uart_pkg: shared defaults and send FSM state type for uart_loop_fifo
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_BUSY_TO = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } send_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------
// sync_fifo: power-of-two synchronous FIFO, accepts a push when full if a pop coincides
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_pop;
  logic              do_push;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO frees its head slot on the same edge a pop happens.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/uart_loop_fifo.sv
// ----------------------------------------------------------------
// uart_loop_fifo: queues received words and replays them to a transmitter
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module uart_loop_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int BUSY_TO = DEF_BUSY_TO
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   recv_done,
  input  logic [DATA_W-1:0]      recv_data,
  input  logic                   tx_busy,
  input  logic                   clr_overflow,
  output logic                   send_en,
  output logic [DATA_W-1:0]      send_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int TW = $clog2(BUSY_TO + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

  send_state_t       state;
  logic [TW-1:0]     to_cnt;
  logic              d0;
  logic              d1;
  logic              rx_flag;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign rx_flag = d0 & ~d1;
  assign pop     = (state == ST_IDLE) & ~fifo_empty & ~tx_busy;
  assign drop    = rx_flag & fifo_full & ~pop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (rx_flag),
    .pop   (pop),
    .wdata (recv_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      d0       <= 1'b0;
      d1       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      d0 <= recv_done;
      d1 <= d0;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      send_en   <= 1'b0;
      send_data <= '0;
      to_cnt    <= '0;
    end else begin
      send_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            send_data <= fifo_rdata;
            send_en   <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          to_cnt <= '0;
          state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // Give up on a transmitter that never acknowledges after BUSY_TO cycles.
          if (tx_busy)                state  <= ST_WAIT_IDLE;
          else if (to_cnt == TO_LAST) state  <= ST_IDLE;
          else                        to_cnt <= to_cnt + 1'b1;
        end
        ST_WAIT_IDLE: begin
          if (!tx_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_loop_fifo.sv
// ----------------------------------------------------------------
// tb_uart_loop_fifo: directed and randomized checks against a queue model
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_uart_loop_fifo;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 8;
  localparam int BUSY_TO = 4;

  logic              clk;
  logic              rst_n;
  logic              recv_done;
  logic [DATA_W-1:0] recv_data;
  logic              tx_busy;
  logic              clr_overflow;
  logic              send_en;
  logic [DATA_W-1:0] send_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              overflow;

  uart_loop_fifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .recv_done    (recv_done),
    .recv_data    (recv_data),
    .tx_busy      (tx_busy),
    .clr_overflow (clr_overflow),
    .send_en      (send_en),
    .send_data    (send_data),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Words the transmitter must see, in order.
  logic [DATA_W-1:0] exp_q[$];

  // Transmitter behaviour: 0 idle, 1 held busy, 2 responds, 3 never responds.
  int tx_mode  = 0;
  int busy_len = 10;
  int cyc      = 0;
  int last_cyc = -100;
  int last_gap = 0;
  int sent_cnt = 0;
  logic [DATA_W-1:0] last_data = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model and send monitor.
  initial begin
    int  remain;
    bit  pend;
    remain  = 0;
    pend    = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (send_en === 1'b1) begin
        check("send_spacing", 32'(cyc - last_cyc >= 3), 32'd1);
        last_gap = cyc - last_cyc;
        last_cyc = cyc;
        if (exp_q.size() > 0) check("send_data_order", 32'(send_data), 32'(exp_q.pop_front()));
        else check("send_en_unexpected", 32'(send_en), 32'd0);
        last_data = send_data;
        sent_cnt++;
      end
      case (tx_mode)
        1: begin tx_busy = 1'b1; pend = 1'b0; remain = 0; end
        2: begin
          if (send_en === 1'b1) pend = 1'b1;
          else if (pend) begin
            pend   = 1'b0;
            remain = busy_len;
          end
          tx_busy = (remain > 0);
          if (remain > 0) remain--;
        end
        default: begin tx_busy = 1'b0; pend = 1'b0; remain = 0; end
      endcase
    end
  end

  task automatic push_word(input logic [DATA_W-1:0] w);
    @(negedge clk);
    recv_data = w;
    recv_done = 1'b1;
    repeat (2) @(negedge clk);
    recv_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sent(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (sent_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check(tag, 32'(sent_cnt), 32'(n));
  endtask

  initial begin
    int base;
    int n;
    logic [DATA_W-1:0] w;

    rst_n        = 1'b0;
    recv_done    = 1'b0;
    recv_data    = '0;
    clr_overflow = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_send_en",    32'(send_en),    32'd0);
    check("rst_send_data",  32'(send_data),  32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    rst_n = 1'b1;

    // Single word with a responsive transmitter.
    tx_mode  = 2;
    busy_len = 10;
    exp_q.push_back(8'h5A);
    push_word(8'h5A);
    wait_sent("single_sent", 1, 50);
    repeat (15) @(negedge clk);
    check("single_data",  32'(last_data),  32'h5A);
    check("single_count", 32'(fifo_count), 32'd0);
    check("single_pulses", 32'(sent_cnt),  32'd1);

    // Burst held back by a busy transmitter, then released.
    tx_mode = 1;
    repeat (2) @(negedge clk);
    base = sent_cnt;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(DATA_W'(i));
      push_word(DATA_W'(i));
    end
    check("burst_count",   32'(fifo_count), 32'd5);
    check("burst_no_send", 32'(sent_cnt),   32'(base));
    busy_len = 2;
    tx_mode  = 2;
    wait_sent("burst_sent", base + 5, 200);
    repeat (8) @(negedge clk);
    check("burst_drained", 32'(fifo_count), 32'd0);

    // Transmitter never acknowledges: each word leaves after a timeout.
    tx_mode = 3;
    base    = sent_cnt;
    exp_q.push_back(8'hA7);
    exp_q.push_back(8'h3C);
    push_word(8'hA7);
    push_word(8'h3C);
    wait_sent("timeout_sent", base + 2, 100);
    check("timeout_gap", 32'(last_gap), 32'(BUSY_TO + 2));
    repeat (10) @(negedge clk);
    check("timeout_count", 32'(fifo_count), 32'd0);

    // Overflow: DEPTH+2 words into a stalled FIFO.
    tx_mode = 1;
    repeat (2) @(negedge clk);
    base = sent_cnt;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) exp_q.push_back(DATA_W'(8'h10 + i));
      push_word(DATA_W'(8'h10 + i));
    end
    check("ovf_count", 32'(fifo_count), 32'(DEPTH));
    check("ovf_flag",  32'(overflow),   32'd1);
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Drop and clear on the same edge: the drop must win.
    @(negedge clk);
    recv_data = 8'hEE;
    recv_done = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    recv_done    = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    repeat (2) @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_cleared2", 32'(overflow),   32'd0);
    check("ovf_no_send",  32'(sent_cnt),   32'(base));

    // Full FIFO, push lands on the same edge as the first pop.
    exp_q.push_back(8'h99);
    @(negedge clk);
    recv_data = 8'h99;
    recv_done = 1'b1;
    @(negedge clk);
    tx_mode = 0;
    @(negedge clk);
    check("full_pp_count",   32'(fifo_count), 32'(DEPTH));
    check("full_pp_ovf",     32'(overflow),   32'd0);
    check("full_pp_send_en", 32'(send_en),    32'd1);
    check("full_pp_data",    32'(send_data),  32'(exp_q[0]));
    recv_done = 1'b0;
    busy_len  = 2;
    tx_mode   = 2;
    wait_sent("full_pp_sent", base + DEPTH + 1, 400);
    repeat (8) @(negedge clk);
    check("full_pp_drained", 32'(fifo_count), 32'd0);
    check("full_pp_ovf_end", 32'(overflow),   32'd0);

    // Randomized batches against the queue model.
    for (int b = 0; b < 4; b++) begin
      busy_len = int'($urandom_range(1, 6));
      n        = int'($urandom_range(2, 6));
      base     = sent_cnt;
      for (int i = 0; i < n; i++) begin
        w = DATA_W'($urandom_range(0, 255));
        exp_q.push_back(w);
        push_word(w);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_sent("rand_sent", base + n, 300);
      repeat (12) @(negedge clk);
      check("rand_count",    32'(fifo_count), 32'd0);
      check("rand_overflow", 32'(overflow),   32'd0);
    end
    check("rand_model_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three words queued and the FSM waiting for tx idle.
    busy_len = 40;
    tx_mode  = 2;
    base     = sent_cnt;
    exp_q.push_back(8'hC1);
    push_word(8'hC1);
    push_word(8'hC2);
    push_word(8'hC3);
    push_word(8'hC4);
    check("mid_queued", 32'(fifo_count), 32'd3);
    check("mid_sent",   32'(sent_cnt),   32'(base + 1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_send_en",    32'(send_en),    32'd0);
    check("async_send_data",  32'(send_data),  32'd0);
    check("async_fifo_count", 32'(fifo_count), 32'd0);
    check("async_overflow",   32'(overflow),   32'd0);
    @(negedge clk);
    tx_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_no_send", 32'(sent_cnt),   32'(base + 1));
    check("post_rst_count",   32'(fifo_count), 32'd0);
    busy_len = 3;
    tx_mode  = 2;
    exp_q.push_back(8'h42);
    push_word(8'h42);
    wait_sent("post_rst_sent", base + 2, 50);
    check("post_rst_data", 32'(last_data), 32'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
